// File: rtl/ge_pkg.sv
// Shared types and default constants for the effect datapath sequencer and
// the bus-side register file.
package ge_pkg;

   localparam int DATA_W      = 32;
   localparam int TIMEOUT     = 64;
   localparam int ACLR_CYCLES = 4;
   localparam int CNT_W       = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      PUSH  = 3'd4,
      FLUSH = 3'd5
   } seq_state_t;

endpackage

// File: rtl/ge_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module ge_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/effect_sequencer.sv
// Moves one sample at a time from the input FIFO through the effect core (or
// straight across in bypass) into the output FIFO, with core timeout and flush.
//
// state | meaning
// IDLE  | waiting for a sample or a pending soft reset
// LATCH | popped data is on in_data; capture it and pick core or bypass
// START | core_start high, timeout timer loaded
// WAIT  | waiting for core_done, timer running
// PUSH  | out_data valid, waiting for room in the output FIFO
// FLUSH | core_aclr high for ACLR_CYCLES cycles
module effect_sequencer #(
   parameter int DATA_W      = ge_pkg::DATA_W,
   parameter int TIMEOUT     = ge_pkg::TIMEOUT,
   parameter int ACLR_CYCLES = ge_pkg::ACLR_CYCLES,
   parameter int CNT_W       = ge_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              soft_reset,
   input  logic              bypass,
   input  logic              in_empty,
   output logic              in_rd,
   input  logic [DATA_W-1:0] in_data,
   output logic              core_aclr,
   output logic              core_start,
   output logic [DATA_W-1:0] core_in,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_out,
   input  logic              out_full,
   output logic              out_wr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);
   import ge_pkg::*;

   localparam int TMR_W = $clog2((TIMEOUT > ACLR_CYCLES) ? TIMEOUT : ACLR_CYCLES);

   seq_state_t       state, state_nxt;
   logic             soft_pend;
   logic             take_soft;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_tc;
   logic             timed_out;

   assign take_soft = soft_reset | soft_pend;
   assign timed_out = (state == WAIT) && !core_done && tmr_tc;
   assign busy      = (state != IDLE);

   // The FIFO strobes are qualified by the flags of the same cycle so a pop
   // can never hit an empty FIFO and a push can never hit a full one.
   assign in_rd  = (state == IDLE) && !take_soft && enable && !in_empty;
   assign out_wr = (state == PUSH) && !out_full;

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         IDLE: begin
            if (take_soft) begin
               state_nxt = FLUSH;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(ACLR_CYCLES - 1);
            end else if (enable && !in_empty) begin
               state_nxt = LATCH;
            end
         end
         LATCH: state_nxt = bypass ? PUSH : START;
         START: begin
            state_nxt = WAIT;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(TIMEOUT - 1);
         end
         WAIT: begin
            if (core_done) begin
               state_nxt = PUSH;
            end else if (tmr_tc) begin
               state_nxt = FLUSH;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(ACLR_CYCLES - 1);
            end
         end
         PUSH:    if (!out_full) state_nxt = IDLE;
         FLUSH:   if (tmr_tc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   ge_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         soft_pend   <= 1'b0;
         core_start  <= 1'b0;
         core_aclr   <= 1'b0;
         core_in     <= '0;
         out_data    <= '0;
         timeout_err <= 1'b0;
         sample_cnt  <= '0;
         drop_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         core_start <= (state_nxt == START);
         core_aclr  <= (state_nxt == FLUSH);

         // A soft reset seen mid-transaction waits for IDLE to be taken.
         if (state == IDLE) begin
            soft_pend <= 1'b0;
         end else if (soft_reset) begin
            soft_pend <= 1'b1;
         end

         if (state == LATCH) begin
            core_in <= in_data;
            if (bypass) out_data <= in_data;
         end
         if (state == WAIT && core_done) out_data <= core_out;

         if (state == IDLE && take_soft) begin
            timeout_err <= 1'b0;
         end else if (timed_out) begin
            timeout_err <= 1'b1;
         end

         if (out_wr) sample_cnt <= sample_cnt + CNT_W'(1);
         if (timed_out && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_effect_sequencer.sv
// Scoreboard bench for effect_sequencer: FIFO and core models drive the DUT,
// expected outputs are queued at stimulus time and checked by monitors.
module tb_effect_sequencer;
   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          soft_reset = 1'b0;
   logic          bypass = 1'b0;
   logic          in_empty = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          core_done = 1'b0;
   logic [DW-1:0] core_out = '0;
   logic          out_full = 1'b0;
   logic          in_rd, core_aclr, core_start, out_wr, busy, timeout_err;
   logic [DW-1:0] core_in, out_data;
   logic [CW-1:0] sample_cnt, drop_cnt;

   int total = 0;
   int bad = 0;
   logic [31:0] in_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] core_q[$];
   int cyc = 0, rd_cyc = 0, wr_cyc = 0, wr_count = 0, start_count = 0;
   int exp_samples = 0;
   int fixed_delay = -1;
   bit hang = 1'b0, full_rand = 1'b0;

   effect_sequencer dut (
      .clk(clk), .reset(reset), .enable(enable), .soft_reset(soft_reset),
      .bypass(bypass), .in_empty(in_empty), .in_rd(in_rd), .in_data(in_data),
      .core_aclr(core_aclr), .core_start(core_start), .core_in(core_in),
      .core_done(core_done), .core_out(core_out), .out_full(out_full),
      .out_wr(out_wr), .out_data(out_data), .busy(busy),
      .timeout_err(timeout_err), .sample_cnt(sample_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // expected response is decided here, from the mode in force for this sample
   task automatic push_in(input logic [31:0] v);
      in_q.push_back(v);
      in_empty = 1'b0;
      if (bypass) begin
         exp_q.push_back(v);
         exp_samples++;
      end else begin
         core_q.push_back(v);
         if (!hang) begin
            exp_q.push_back(v + 32'd5);
            exp_samples++;
         end
      end
   endtask

   // input FIFO, normal mode: data appears the cycle after the pop
   initial forever begin
      bit pop_now;
      @(negedge clk);
      pop_now = in_rd && !reset;
      @(posedge clk);
      #1;
      if (pop_now && in_q.size() > 0) in_data = in_q.pop_front();
      in_empty = (in_q.size() == 0);
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (full_rand) out_full = ($urandom_range(0, 3) == 0);
   end

   // core model: result = input + 5, some cycles after core_start
   initial forever begin
      logic [31:0] v;
      int k;
      @(negedge clk);
      if (core_start && !reset) begin
         v = core_in;
         if (core_q.size() == 0) begin
            total++; bad++;
            $display("FAIL core_in: unexpected core_start with %0h", v);
         end else begin
            chk("core_in", v, core_q.pop_front());
         end
         if (!hang) begin
            k = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            @(posedge clk); #1;
            repeat (k) begin @(posedge clk); #1; end
            core_done = 1'b1;
            core_out  = v + 32'd5;
            @(posedge clk); #1;
            core_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (in_rd) begin
            rd_cyc = cyc;
            chk("rd_vs_empty", {31'd0, in_empty}, 0);
         end
         if (core_start) start_count++;
         if (out_wr) begin
            wr_cyc = cyc;
            wr_count++;
            chk("wr_vs_full", {31'd0, out_full}, 0);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL out_data: unexpected push of %0h", out_data);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || in_q.size() != 0 || busy) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_done", {31'd0, n < 3000}, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_start();
      int g = 0;
      while (!core_start && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("start_seen", {31'd0, g < 100}, 1);
   endtask

   task automatic count_aclr(output int n);
      int g = 0;
      n = 0;
      while (!core_aclr && g < 200) begin @(negedge clk); g++; end
      while (core_aclr && n < 200) begin n++; @(negedge clk); end
   endtask

   initial begin
      int n, wc, rc, g;
      repeat (3) @(negedge clk);
      chk("rst_in_rd", {31'd0, in_rd}, 0);
      chk("rst_out_wr", {31'd0, out_wr}, 0);
      chk("rst_start", {31'd0, core_start}, 0);
      chk("rst_aclr", {31'd0, core_aclr}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_terr", {31'd0, timeout_err}, 0);
      chk("rst_scnt", {16'd0, sample_cnt}, 0);
      chk("rst_dcnt", {16'd0, drop_cnt}, 0);
      chk("rst_core_in", core_in, 0);
      chk("rst_out_data", out_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      enable = 1'b1;

      // bypass: pop, latch, push on the third cycle
      bypass = 1'b1;
      push_in(32'h0000_1234);
      drain();
      chk("bypass_lat", wr_cyc - rd_cyc, 2);
      chk("bypass_cnt", {16'd0, sample_cnt}, 1);

      // core path, result in the third WAIT cycle
      bypass = 1'b0;
      fixed_delay = 2;
      push_in(32'd10);
      drain();
      chk("core_lat", wr_cyc - rd_cyc, 6);
      chk("core_starts", start_count, 1);
      for (int i = 0; i < 4; i++) push_in(32'd20 + 32'(i));
      drain();
      chk("core_b2b_cnt", {16'd0, sample_cnt}, 32'(exp_samples));
      chk("core_b2b_starts", start_count, 5);

      // random batches: data, core latency, mode and output backpressure
      fixed_delay = -1;
      for (int b = 0; b < 6; b++) begin
         bypass = 1'($urandom_range(0, 1));
         full_rand = 1'b1;
         for (int j = 0; j < int'($urandom_range(3, 8)); j++) begin
            push_in($urandom);
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
         end
         drain();
         full_rand = 1'b0;
         out_full = 1'b0;
      end
      chk("rand_cnt", {16'd0, sample_cnt}, 32'(exp_samples));

      // backpressure holds the sample indefinitely
      bypass = 1'b1;
      out_full = 1'b1;
      wc = wr_count;
      push_in(32'hCAFE_0001);
      repeat (20) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("bp_data", out_data, 32'hCAFE_0001);
      chk("bp_busy", {31'd0, busy}, 1);
      chk("bp_no_wr", wr_count, wc);
      @(posedge clk); #1;
      out_full = 1'b0;
      drain();
      chk("bp_one_wr", wr_count, wc + 1);

      // core hang -> timeout, drop, flush
      bypass = 1'b0;
      hang = 1'b1;
      push_in(32'h77);
      wait_start();
      n = 0;
      while (!timeout_err && n < 200) begin @(negedge clk); n++; end
      chk("to_cycles", n, 65);
      chk("to_drop", {16'd0, drop_cnt}, 1);
      count_aclr(n);
      chk("to_aclr_len", n, 4);
      chk("to_idle", {31'd0, busy}, 0);
      chk("to_err_sticky", {31'd0, timeout_err}, 1);
      hang = 1'b0;

      @(posedge clk); #1; soft_reset = 1'b1;
      @(posedge clk); #1; soft_reset = 1'b0;
      @(negedge clk);
      chk("sr_clears_err", {31'd0, timeout_err}, 0);
      count_aclr(n);
      chk("sr_aclr_len", n, 4);

      // soft reset in WAIT: sample completes, then flush
      @(posedge clk); #1;
      fixed_delay = 3;
      push_in(32'h55);
      wait_start();
      @(posedge clk); #1; soft_reset = 1'b1;
      @(posedge clk); #1; soft_reset = 1'b0;
      g = 0;
      while (!out_wr && g < 100) begin @(negedge clk); g++; end
      chk("srw_pushed", {31'd0, g < 100}, 1);
      count_aclr(n);
      chk("srw_aclr_len", n, 4);
      drain();
      fixed_delay = -1;

      // enable low: nothing is fetched
      enable = 1'b0;
      bypass = 1'b1;
      for (int i = 0; i < 3; i++) push_in($urandom);
      rc = 0;
      repeat (100) begin
         @(negedge clk);
         if (in_rd) rc++;
      end
      chk("dis_no_rd", rc, 0);
      chk("dis_idle", {31'd0, busy}, 0);
      @(posedge clk); #1;
      enable = 1'b1;
      drain();
      chk("dis_cnt", {16'd0, sample_cnt}, 32'(exp_samples));

      // async reset in WAIT
      bypass = 1'b0;
      hang = 1'b1;
      push_in(32'h99);
      wait_start();
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("ar_in_rd", {31'd0, in_rd}, 0);
      chk("ar_out_wr", {31'd0, out_wr}, 0);
      chk("ar_start", {31'd0, core_start}, 0);
      chk("ar_aclr", {31'd0, core_aclr}, 0);
      chk("ar_busy", {31'd0, busy}, 0);
      chk("ar_scnt", {16'd0, sample_cnt}, 0);
      chk("ar_dcnt", {16'd0, drop_cnt}, 0);
      exp_samples = 0;
      hang = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      bypass = 1'b1;
      push_in(32'hABC);
      drain();
      chk("ar_after_cnt", {16'd0, sample_cnt}, 32'(exp_samples));

      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
